// File: rtl/mips_ctrl_pkg.sv
// Shared opcode, ALU-operation and control-bundle definitions for the MIPS32 ID stage.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // Selects what the ID/EX register does on the next edge.
    typedef enum logic [1:0] {
        EX_HOLD   = 2'd0,
        EX_BUBBLE = 2'd1,
        EX_LOAD   = 2'd2
    } ex_op_t;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       regdst;
        logic       alusrc;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/id_decode.sv
// Combinational opcode decoder: control bundle, illegal flag and operand-use flags.
module id_decode
    import mips_ctrl_pkg::*;
#(
    parameter bit EN_ADDI = 1'b1,
    parameter bit EN_JUMP = 1'b1
) (
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal,
    output logic       uses_rs,
    output logic       uses_rt
);

    always_comb begin
        ctrl    = CTRL_NONE;
        illegal = 1'b0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALU_FUNCT;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_LW: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.aluop    = ALU_ADD;
                uses_rs       = 1'b1;
            end
            OP_SW: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.aluop    = ALU_ADD;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.aluop  = ALU_SUB;
                uses_rs     = 1'b1;
                uses_rt     = 1'b1;
            end
            OP_ADDI: begin
                if (EN_ADDI) begin
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.aluop    = ALU_ADD;
                    uses_rs       = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_J: begin
                if (EN_JUMP) begin
                    ctrl.jump = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_hazard_control.sv
// ID-stage control: decode into the ID/EX register, load-use stall FSM,
// branch/jump flush and external freeze handling.
module id_hazard_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W      = 2,
    parameter bit          EN_ADDI      = 1'b1,
    parameter bit          EN_JUMP      = 1'b1,
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instr_id,
    input  logic               valid_id,
    input  logic               flush_ex,
    input  logic               stall_in,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic               regwrite_ex,
    output logic               memtoreg_ex,
    output logic               branch_ex,
    output logic               memread_ex,
    output logic               memwrite_ex,
    output logic               regdst_ex,
    output logic               alusrc_ex,
    output logic               jump_ex,
    output logic [ALUOP_W-1:0] aluop_ex,
    output logic [4:0]         rs_ex,
    output logic [4:0]         rt_ex,
    output logic [4:0]         rd_ex,
    output logic               valid_ex,
    output logic               illegal_ex
);

    localparam logic [1:0] CNT_INIT = 2'(STALL_CYCLES - 1);

    state_t     state, state_n;
    logic [1:0] cnt, cnt_n;
    ex_op_t     ex_op;

    ctrl_t      dec_ctrl;
    logic       dec_illegal, uses_rs, uses_rt;
    ctrl_t      ctrl_q;
    logic       valid_q, illegal_q;
    logic [4:0] rs_q, rt_q, rd_q;

    logic [4:0] rs_id, rt_id, rd_id;
    logic       is_nop, hazard;

    assign rs_id  = instr_id[25:21];
    assign rt_id  = instr_id[20:16];
    assign rd_id  = instr_id[15:11];
    assign is_nop = (instr_id == 32'd0);

    id_decode #(
        .EN_ADDI (EN_ADDI),
        .EN_JUMP (EN_JUMP)
    ) u_decode (
        .opcode  (instr_id[31:26]),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt)
    );

    // A load in EX whose destination feeds the ID instruction; $0 never hazards.
    assign hazard = (state == RUN) && valid_q && ctrl_q.memread && (rt_q != 5'd0) &&
                    valid_id && ((uses_rs && (rs_id == rt_q)) || (uses_rt && (rt_id == rt_q)));

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        ex_op      = EX_LOAD;
        if (stall_in) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ex_op      = EX_HOLD;
        end else if (flush_ex) begin
            ifid_flush = 1'b1;
            ex_op      = EX_BUBBLE;
            state_n    = RUN;
            cnt_n      = 2'd0;
        end else if (state == STALL) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ex_op      = EX_BUBBLE;
            if (cnt == 2'd1) begin
                state_n = RUN;
                cnt_n   = 2'd0;
            end else begin
                cnt_n = cnt - 2'd1;
            end
        end else if (hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ex_op      = EX_BUBBLE;
            if (STALL_CYCLES > 1) begin
                state_n = STALL;
                cnt_n   = CNT_INIT;
            end
        end else if (!valid_id) begin
            ex_op = EX_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            cnt       <= 2'd0;
            ctrl_q    <= CTRL_NONE;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            rs_q      <= 5'd0;
            rt_q      <= 5'd0;
            rd_q      <= 5'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            case (ex_op)
                EX_BUBBLE: begin
                    ctrl_q    <= CTRL_NONE;
                    valid_q   <= 1'b0;
                    illegal_q <= 1'b0;
                    rs_q      <= 5'd0;
                    rt_q      <= 5'd0;
                    rd_q      <= 5'd0;
                end
                EX_LOAD: begin
                    // The all-zero word decodes as RTYPE, so NOP overrides the bundle.
                    ctrl_q    <= is_nop ? CTRL_NONE : dec_ctrl;
                    valid_q   <= 1'b1;
                    illegal_q <= dec_illegal & ~is_nop;
                    rs_q      <= rs_id;
                    rt_q      <= rt_id;
                    rd_q      <= rd_id;
                end
                default: ;
            endcase
        end
    end

    assign regwrite_ex = ctrl_q.regwrite;
    assign memtoreg_ex = ctrl_q.memtoreg;
    assign branch_ex   = ctrl_q.branch;
    assign memread_ex  = ctrl_q.memread;
    assign memwrite_ex = ctrl_q.memwrite;
    assign regdst_ex   = ctrl_q.regdst;
    assign alusrc_ex   = ctrl_q.alusrc;
    assign jump_ex     = ctrl_q.jump;
    assign aluop_ex    = ALUOP_W'(ctrl_q.aluop);
    assign rs_ex       = rs_q;
    assign rt_ex       = rt_q;
    assign rd_ex       = rd_q;
    assign valid_ex    = valid_q;
    assign illegal_ex  = illegal_q;

endmodule

// File: tb/tb_id_hazard_control.sv
// Bench for id_hazard_control: two configurations driven through an emulated IF/ID
// register, checked against a bubble-counting reference model and an EX scoreboard.
module tb_id_hazard_control;

    localparam int W = 28;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] instr_id [2];
    logic        valid_id [2];
    logic        flush_ex, stall_in;

    logic        pc_write [2], ifid_write [2], ifid_flush [2];
    logic        regwrite_ex [2], memtoreg_ex [2], branch_ex [2], memread_ex [2];
    logic        memwrite_ex [2], regdst_ex [2], alusrc_ex [2], jump_ex [2];
    logic        valid_ex [2], illegal_ex [2];
    logic [4:0]  rs_ex [2], rt_ex [2], rd_ex [2];
    logic [1:0]  aluop_a;
    logic [2:0]  aluop_b;

    int          stall_cfg [2] = '{1, 3};
    bit          en_addi_cfg [2] = '{1'b1, 1'b0};
    bit          en_jump_cfg [2] = '{1'b1, 1'b0};

    id_hazard_control #(.ALUOP_W(2), .EN_ADDI(1'b1), .EN_JUMP(1'b1), .STALL_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .instr_id(instr_id[0]), .valid_id(valid_id[0]),
        .flush_ex(flush_ex), .stall_in(stall_in),
        .pc_write(pc_write[0]), .ifid_write(ifid_write[0]), .ifid_flush(ifid_flush[0]),
        .regwrite_ex(regwrite_ex[0]), .memtoreg_ex(memtoreg_ex[0]), .branch_ex(branch_ex[0]),
        .memread_ex(memread_ex[0]), .memwrite_ex(memwrite_ex[0]), .regdst_ex(regdst_ex[0]),
        .alusrc_ex(alusrc_ex[0]), .jump_ex(jump_ex[0]), .aluop_ex(aluop_a),
        .rs_ex(rs_ex[0]), .rt_ex(rt_ex[0]), .rd_ex(rd_ex[0]),
        .valid_ex(valid_ex[0]), .illegal_ex(illegal_ex[0])
    );

    id_hazard_control #(.ALUOP_W(3), .EN_ADDI(1'b0), .EN_JUMP(1'b0), .STALL_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .instr_id(instr_id[1]), .valid_id(valid_id[1]),
        .flush_ex(flush_ex), .stall_in(stall_in),
        .pc_write(pc_write[1]), .ifid_write(ifid_write[1]), .ifid_flush(ifid_flush[1]),
        .regwrite_ex(regwrite_ex[1]), .memtoreg_ex(memtoreg_ex[1]), .branch_ex(branch_ex[1]),
        .memread_ex(memread_ex[1]), .memwrite_ex(memwrite_ex[1]), .regdst_ex(regdst_ex[1]),
        .alusrc_ex(alusrc_ex[1]), .jump_ex(jump_ex[1]), .aluop_ex(aluop_b),
        .rs_ex(rs_ex[1]), .rt_ex(rt_ex[1]), .rd_ex(rd_ex[1]),
        .valid_ex(valid_ex[1]), .illegal_ex(illegal_ex[1])
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q0 [$];
    logic [W-1:0] exp_q1 [$];
    logic [31:0]  dir_q0 [$];
    logic [31:0]  dir_q1 [$];

    // Reference model: what EX holds, bubbles still owed, and the IF/ID action for next edge.
    logic [W-1:0] ex_m [2];
    int           bub_left [2];
    int           ifid_act [2];
    logic         exp_pc [2], exp_ifw [2], exp_iff [2];
    int           stall_burst = 0;

    // Item layout: valid, illegal, regwrite, memtoreg, branch, memread, memwrite,
    // regdst, alusrc, jump, aluop[2:0], rs, rt, rd.
    function automatic logic [W-1:0] pack(logic v, logic il, logic rw, logic mtr, logic br,
                                          logic mr, logic mw, logic rdst, logic as, logic j,
                                          logic [2:0] op, logic [4:0] rs, logic [4:0] rt,
                                          logic [4:0] rd);
        return {v, il, rw, mtr, br, mr, mw, rdst, as, j, op, rs, rt, rd};
    endfunction

    function automatic logic [W-1:0] ref_decode(int l, logic [31:0] ins);
        logic rw, mtr, br, mr, mw, rdst, as, j, il;
        logic [2:0] aop;
        {rw, mtr, br, mr, mw, rdst, as, j, il} = '0;
        aop = 3'd0;
        if (ins != 32'd0) begin
            case (ins[31:26])
                6'h00: begin rdst = 1; rw = 1; aop = 3'd2; end
                6'h23: begin as = 1; mr = 1; rw = 1; mtr = 1; end
                6'h2b: begin as = 1; mw = 1; end
                6'h04: begin br = 1; aop = 3'd1; end
                6'h08: if (en_addi_cfg[l]) begin as = 1; rw = 1; end else il = 1;
                6'h02: if (en_jump_cfg[l]) j = 1; else il = 1;
                default: il = 1;
            endcase
        end
        return pack(1'b1, il, rw, mtr, br, mr, mw, rdst, as, j, aop,
                    ins[25:21], ins[20:16], ins[15:11]);
    endfunction

    function automatic bit ref_hazard(int l);
        logic [5:0] op;
        logic [4:0] ld_rt;
        bit u_rs, u_rt;
        op    = instr_id[l][31:26];
        ld_rt = ex_m[l][9:5];
        u_rs  = (op == 6'h00) || (op == 6'h23) || (op == 6'h2b) || (op == 6'h04) ||
                ((op == 6'h08) && en_addi_cfg[l]);
        u_rt  = (op == 6'h00) || (op == 6'h2b) || (op == 6'h04);
        if (!(ex_m[l][27] && ex_m[l][22] && ld_rt != 5'd0 && valid_id[l])) return 1'b0;
        return (u_rs && instr_id[l][25:21] == ld_rt) || (u_rt && instr_id[l][20:16] == ld_rt);
    endfunction

    function automatic logic [31:0] rand_instr();
        int k;
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        logic [10:0] lo;
        k  = $urandom_range(0, 9);
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 7));
        lo = 11'($urandom);
        case (k)
            0, 1: op = 6'h00;
            2, 3: op = 6'h23;
            4: op = 6'h2b;
            5: op = 6'h04;
            6: op = 6'h08;
            7: op = 6'h02;
            8: return 32'd0;
            default: begin
                case ($urandom_range(0, 2))
                    0: op = 6'h3f;
                    1: op = 6'h03;
                    default: op = 6'h0d;
                endcase
            end
        endcase
        return {op, rs, rt, rd, lo};
    endfunction

    function automatic logic [W-1:0] dut_item(int l);
        if (l == 0)
            return pack(valid_ex[0], illegal_ex[0], regwrite_ex[0], memtoreg_ex[0], branch_ex[0],
                        memread_ex[0], memwrite_ex[0], regdst_ex[0], alusrc_ex[0], jump_ex[0],
                        {1'b0, aluop_a}, rs_ex[0], rt_ex[0], rd_ex[0]);
        return pack(valid_ex[1], illegal_ex[1], regwrite_ex[1], memtoreg_ex[1], branch_ex[1],
                    memread_ex[1], memwrite_ex[1], regdst_ex[1], alusrc_ex[1], jump_ex[1],
                    aluop_b, rs_ex[1], rt_ex[1], rd_ex[1]);
    endfunction

    task automatic chk(string name, int l, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d actual=%h required=%h t=%0t", name, l, act, exp, $time);
        end
    endtask

    task automatic chk_enables(string tag);
        for (int l = 0; l < 2; l++) begin
            chk({tag, "_pc_write"}, l, W'(pc_write[l]), W'(exp_pc[l]));
            chk({tag, "_ifid_write"}, l, W'(ifid_write[l]), W'(exp_ifw[l]));
            chk({tag, "_ifid_flush"}, l, W'(ifid_flush[l]), W'(exp_iff[l]));
        end
    endtask

    task automatic model_reset();
        exp_q0.delete();
        exp_q1.delete();
        for (int l = 0; l < 2; l++) begin
            ex_m[l]     = '0;
            bub_left[l] = 0;
            ifid_act[l] = 0;
            instr_id[l] = 32'd0;
            valid_id[l] = 1'b0;
            exp_pc[l]   = 1'b1;
            exp_ifw[l]  = 1'b1;
            exp_iff[l]  = 1'b0;
        end
    endtask

    task automatic check_reset_state(string tag);
        for (int l = 0; l < 2; l++) chk({tag, "_ex_bundle"}, l, dut_item(l), '0);
        chk_enables(tag);
    endtask

    // One cycle: load IF/ID, pick controls, run the model, check enables before the edge.
    task automatic step(bit rnd);
        logic [W-1:0] nxt;
        @(negedge clk);
        rst_n = 1'b1;
        for (int l = 0; l < 2; l++) begin
            if (ifid_act[l] == 1) begin
                instr_id[l] = 32'd0;
                valid_id[l] = 1'b0;
            end else if (ifid_act[l] == 2) begin
                if (l == 0 && dir_q0.size() > 0) begin
                    instr_id[l] = dir_q0.pop_front();
                    valid_id[l] = 1'b1;
                end else if (l == 1 && dir_q1.size() > 0) begin
                    instr_id[l] = dir_q1.pop_front();
                    valid_id[l] = 1'b1;
                end else if ($urandom_range(0, 11) == 0) begin
                    instr_id[l] = $urandom;
                    valid_id[l] = 1'b0;
                end else begin
                    instr_id[l] = rand_instr();
                    valid_id[l] = 1'b1;
                end
            end
        end
        if (rnd) begin
            if (stall_burst > 0) begin
                stall_in    = 1'b1;
                stall_burst = stall_burst - 1;
            end else if ($urandom_range(0, 15) == 0) begin
                stall_in    = 1'b1;
                stall_burst = $urandom_range(0, 3);
            end else begin
                stall_in = 1'b0;
            end
            flush_ex = ($urandom_range(0, 11) == 0);
        end else begin
            stall_in    = 1'b0;
            flush_ex    = 1'b0;
            stall_burst = 0;
        end
        for (int l = 0; l < 2; l++) begin
            if (stall_in) begin
                {exp_pc[l], exp_ifw[l], exp_iff[l]} = 3'b000;
                ifid_act[l] = 0;
            end else begin
                if (flush_ex) begin
                    {exp_pc[l], exp_ifw[l], exp_iff[l]} = 3'b111;
                    nxt = '0;
                    bub_left[l] = 0;
                    ifid_act[l] = 1;
                end else if (bub_left[l] > 0) begin
                    {exp_pc[l], exp_ifw[l], exp_iff[l]} = 3'b000;
                    nxt = '0;
                    bub_left[l] = bub_left[l] - 1;
                    ifid_act[l] = 0;
                end else if (ref_hazard(l)) begin
                    {exp_pc[l], exp_ifw[l], exp_iff[l]} = 3'b000;
                    nxt = '0;
                    bub_left[l] = stall_cfg[l] - 1;
                    ifid_act[l] = 0;
                end else begin
                    {exp_pc[l], exp_ifw[l], exp_iff[l]} = 3'b110;
                    nxt = valid_id[l] ? ref_decode(l, instr_id[l]) : '0;
                    ifid_act[l] = 2;
                end
                ex_m[l] = nxt;
                if (l == 0) exp_q0.push_back(nxt);
                else exp_q1.push_back(nxt);
            end
        end
        #1;
        chk_enables("enable");
    endtask

    // Monitor: every unfrozen edge out of reset presents a new EX slot to compare.
    initial begin
        logic frozen, live;
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            frozen = stall_in;
            live   = rst_n;
            #2;
            if (live && !frozen) begin
                for (int l = 0; l < 2; l++) begin
                    if ((l == 0 && exp_q0.size() == 0) || (l == 1 && exp_q1.size() == 0)) begin
                        chk("ex_queue_empty", l, W'(1), W'(0));
                    end else begin
                        e = (l == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk("ex_bundle", l, dut_item(l), e);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        rst_n    = 1'b1;
        flush_ex = 1'b0;
        stall_in = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("reset");
        repeat (2) @(negedge clk);

        foreach (dir_q0[i]) ;
        dir_q0 = '{32'h00221820, 32'h8C220000, 32'h00441820, 32'h8C000000, 32'h00001820,
                   32'h8C220000, 32'h8C250000, 32'hFC000000, 32'h20220005, 32'h08000010,
                   32'h8C430000, 32'hAC630000, 32'h00000000};
        dir_q1 = dir_q0;

        repeat (40) step(1'b0);
        repeat (3000) step(1'b1);

        // Steer the STALL_CYCLES=3 lane into a stall, then reset in the middle of it.
        dir_q0.push_back(32'h8C220000);
        dir_q0.push_back(32'h00441820);
        dir_q1.push_back(32'h8C220000);
        dir_q1.push_back(32'h00441820);
        guard = 0;
        do begin
            step(1'b0);
            guard++;
        end while (bub_left[1] == 0 && guard < 60);
        checks++;
        if (bub_left[1] == 0) begin
            errors++;
            $display("FAIL stall_not_reached lane1 actual=0 required=nonzero");
        end
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        dir_q0.delete();
        dir_q1.delete();
        #1;
        check_reset_state("mid_stall_reset");
        repeat (2) @(negedge clk);
        repeat (60) step(1'b1);
        @(negedge clk);
        stall_in = 1'b0;
        flush_ex = 1'b0;
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
